pkt_rx_ctrl: RTL
================

PKT_RX_CTRL -- requirements
Module: pkt_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, buffer depth in 64-bit words (power of 2).
REQ-002 Parameter FULL_THRESH, default 12, occupancy at which pkt_rx_full asserts; SHALL satisfy FIFO_DEPTH-FULL_THRESH >= 4.
REQ-003 clk_156m25  in  1  sole clock, all logic on its rising edge.
REQ-004 reset_156m25_n  in  1  reset, asynchronous, active-low.
REQ-005 pkt_rx_data  in  64  receive word from MAC.
REQ-006 pkt_rx_val  in  1  word valid this cycle.
REQ-007 pkt_rx_sop / pkt_rx_eop  in  1 each  first / last word of packet.
REQ-008 pkt_rx_mod  in  3  valid bytes on eop word; 0 = all 8.
REQ-009 pkt_rx_full  out  1  backpressure to MAC; registered.
REQ-010 out_data  out  64; out_sop, out_eop  out  1; out_mod  out  3; out_err  out  1  buffered stream.
REQ-011 out_val  out  1 / out_rdy  in  1  downstream valid/ready handshake.
REQ-012 clr_cnt  in  1  synchronous counter clear.
REQ-013 pkt_cnt  out  32  good packets; byte_cnt  out  32  bytes of good packets; err_cnt, ovf_cnt  out  16  framing errors, overflow events.

Function
REQ-014 Word accepted when pkt_rx_val=1 at a rising edge; SHALL be written into FIFO same edge unless dropped.
REQ-015 FIFO is first-word-fall-through: word written at edge k SHALL appear on out_* with out_val=1 in cycle after edge k if FIFO was empty (latency 1).
REQ-016 Pop SHALL occur when out_val&out_rdy; out_* SHALL hold stable while out_val&!out_rdy.
REQ-017 Simultaneous push and pop SHALL leave occupancy unchanged; pop when empty impossible (out_val=0).
REQ-018 pkt_rx_full SHALL equal registered (occupancy >= FULL_THRESH), updated every edge.
REQ-019 Framing FSM states IDLE, IN_PKT, DROP.
REQ-020 IDLE: val&sop&!eop -> IN_PKT, word written; val&sop&eop -> single-word packet written, stay IDLE; val&!sop -> word discarded, err_cnt+1, stay IDLE.
REQ-021 IN_PKT: val&!sop&eop -> written, -> IDLE; val&!sop&!eop -> written, stay; val&sop -> err_cnt+1, word written as new sop with out_err=1, remain/exit per its eop.
REQ-022 out_err=1 on a sop word SHALL mean previous packet terminated without eop; out_err=0 on all other words.
REQ-023 Push attempted with occupancy==FIFO_DEPTH (pop same cycle does not rescue) SHALL drop word, ovf_cnt+1, enter DROP, set pending_err.
REQ-024 DROP: all words discarded until val&eop -> IDLE; val&sop in DROP -> treated as IDLE sop (leaves DROP).
REQ-025 pending_err SHALL force out_err=1 on next written sop word, then clear.
REQ-026 On eop written from a packet whose sop had no subsequent loss: pkt_cnt+1 and byte_cnt += 8*(words-1) + (mod==0 ? 8 : mod).
REQ-027 pkt_cnt, byte_cnt wrap modulo 2^32; err_cnt, ovf_cnt saturate at 16'hFFFF.
REQ-028 clr_cnt=1 SHALL zero all counters at that edge; clear wins over coincident increment.

Reset
REQ-029 Reset asserted SHALL immediately: flush FIFO (occupancy 0, out_val=0), FSM=IDLE, pending_err=0, pkt_rx_full=0, all counters 0, out_data/out_mod 0, out_sop/eop/err 0.
REQ-030 Reset mid-packet SHALL discard partial packet with no counter update; first post-reset word handled from IDLE.

Structure
REQ-031 Shared package pkt_rx_pkg SHALL hold the FSM state enum, FIFO word struct (data, sop, eop, mod, err; 70 bits) and mod-to-bytes function.
REQ-032 FIFO SHALL be a sub-module pkt_rx_fifo (sync FWFT, DEPTH parameter, occupancy output); FSM, flow control and counters in pkt_rx_ctrl.

Verification
REQ-033 3-word packet sop/-/eop mod=5, out_rdy=1 -> words out in order, latency 1, pkt_cnt=1, byte_cnt=21.
REQ-034 Single word sop&eop mod=0 -> pkt_cnt=1, byte_cnt=8.
REQ-035 out_rdy=0, stream 12 words -> pkt_rx_full=1 after 12th write edge; pop 1 -> full=0 next edge.
REQ-036 Stream 17 words with out_rdy=0 -> 17th dropped, ovf_cnt=1, FSM DROP; next packet's sop out_err=1, pkt_cnt unchanged for the truncated packet.
REQ-037 Word without sop in IDLE -> discarded, err_cnt=1; sop while IN_PKT -> err_cnt=2, that sop has out_err=1.
REQ-038 Reset asserted mid-packet with 5 words buffered -> out_val=0, counters 0 immediately; clr_cnt coincident with eop -> pkt_cnt=0.

Source files
------------

// File: rtl/pkt_rx_pkg.sv
// pkt_rx_pkg: shared framing state enum, 70-bit FIFO word and mod-to-bytes helper
package pkt_rx_pkg;
  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;
  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
  } word_t;
  function automatic logic [3:0] mod_bytes(input logic [2:0] m);
    return (m == 3'd0) ? 4'd8 : {1'b0, m};
  endfunction
endpackage

// File: rtl/pkt_rx_ctrl_if.sv
// pkt_rx_ctrl_if: MAC receive stream (val/sop/eop/mod, full backpressure) and buffered output stream (val/rdy)
// master drives MAC words and out_rdy; slave is the controller.
interface pkt_rx_ctrl_if;
  logic [63:0] pkt_rx_data;
  logic        pkt_rx_val;
  logic        pkt_rx_sop;
  logic        pkt_rx_eop;
  logic [2:0]  pkt_rx_mod;
  logic        pkt_rx_full;
  logic [63:0] out_data;
  logic        out_val;
  logic        out_rdy;
  logic        out_sop;
  logic        out_eop;
  logic [2:0]  out_mod;
  logic        out_err;
  modport master (
    output pkt_rx_data, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, out_rdy,
    input  pkt_rx_full, out_data, out_val, out_sop, out_eop, out_mod, out_err
  );
  modport slave (
    input  pkt_rx_data, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, out_rdy,
    output pkt_rx_full, out_data, out_val, out_sop, out_eop, out_mod, out_err
  );
endinterface

// File: rtl/pkt_rx_fifo.sv
// pkt_rx_fifo: synchronous first-word-fall-through FIFO of word_t
// ports: clk, rst_n (async active-low), wr_en/wr_data push, rd_en pop,
//        rd_data/rd_val head word (zero while empty), count occupancy.
// The caller never pushes when full nor pops when empty.
module pkt_rx_fifo
  import pkt_rx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  word_t                    wr_data,
  input  logic                     rd_en,
  output word_t                    rd_data,
  output logic                     rd_val,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  word_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (wr_en) mem[wp] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(wr_en);
      rp    <= rp + AW'(rd_en);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  assign rd_val  = count != '0;
  assign rd_data = rd_val ? mem[rp] : '0;
endmodule

// File: rtl/pkt_rx_ctrl.sv
// pkt_rx_ctrl: MAC receive framing checker, overflow handling, FWFT buffering and statistics
// ports: clk_156m25, reset_156m25_n (async active-low), bus (pkt_rx_ctrl_if.slave),
//        clr_cnt sync counter clear, pkt_cnt/byte_cnt (wrap), err_cnt/ovf_cnt (saturate).
module pkt_rx_ctrl
  import pkt_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FULL_THRESH = 12
) (
  input  logic          clk_156m25,
  input  logic          reset_156m25_n,
  pkt_rx_ctrl_if.slave  bus,
  input  logic          clr_cnt,
  output logic [31:0]   pkt_cnt,
  output logic [31:0]   byte_cnt,
  output logic [15:0]   err_cnt,
  output logic [15:0]   ovf_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] THRESH_C = (AW+1)'(FULL_THRESH);
  state_t      state;
  logic        pending_err;
  logic [28:0] wcnt;
  logic [AW:0] occ, occ_nxt;
  logic        want_wr, wr_en, rd_en, ovf, err_inc, good_eop;
  logic [31:0] pkt_bytes;
  word_t       wr_word, rd_word;
  always_comb begin
    want_wr   = bus.pkt_rx_val & (bus.pkt_rx_sop | state == IN_PKT);
    ovf       = want_wr & (occ == DEPTH_C);
    wr_en     = want_wr & ~ovf;
    rd_en     = bus.out_val & bus.out_rdy;
    occ_nxt   = occ + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    err_inc   = bus.pkt_rx_val & (bus.pkt_rx_sop ? state == IN_PKT : state == IDLE);
    good_eop  = wr_en & bus.pkt_rx_eop;
    // wcnt holds words already written for this packet, excluding the eop word
    pkt_bytes = (bus.pkt_rx_sop ? 32'd0 : {wcnt, 3'b000}) + 32'(mod_bytes(bus.pkt_rx_mod));
    wr_word   = '{data: bus.pkt_rx_data, sop: bus.pkt_rx_sop, eop: bus.pkt_rx_eop,
                  mod: bus.pkt_rx_mod, err: bus.pkt_rx_sop & (state == IN_PKT | pending_err)};
  end
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n)
    if (!reset_156m25_n) begin
      state           <= IDLE;
      pending_err     <= 1'b0;
      wcnt            <= '0;
      bus.pkt_rx_full <= 1'b0;
      pkt_cnt         <= '0;
      byte_cnt        <= '0;
      err_cnt         <= '0;
      ovf_cnt         <= '0;
    end else begin
      bus.pkt_rx_full <= occ_nxt >= THRESH_C;
      // any sop restarts framing (also leaves DROP); eop always closes it
      if (ovf) state <= DROP;
      else if (bus.pkt_rx_val) state <= bus.pkt_rx_eop ? IDLE : (bus.pkt_rx_sop ? IN_PKT : state);
      if (ovf) pending_err <= 1'b1;
      else if (wr_en & bus.pkt_rx_sop) pending_err <= 1'b0;
      if (wr_en) wcnt <= bus.pkt_rx_sop ? 29'd1 : wcnt + 29'd1;
      if (clr_cnt) begin
        pkt_cnt  <= '0;
        byte_cnt <= '0;
        err_cnt  <= '0;
        ovf_cnt  <= '0;
      end else begin
        if (good_eop) begin
          pkt_cnt  <= pkt_cnt + 32'd1;
          byte_cnt <= byte_cnt + pkt_bytes;
        end
        if (err_inc & ~&err_cnt) err_cnt <= err_cnt + 16'd1;
        if (ovf & ~&ovf_cnt) ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  pkt_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_156m25),
    .rst_n   (reset_156m25_n),
    .wr_en   (wr_en),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_data (rd_word),
    .rd_val  (bus.out_val),
    .count   (occ)
  );
  assign bus.out_data = rd_word.data;
  assign bus.out_sop  = rd_word.sop;
  assign bus.out_eop  = rd_word.eop;
  assign bus.out_mod  = rd_word.mod;
  assign bus.out_err  = rd_word.err;
endmodule
